pixel_framebuffer_scanner: RTL
==============================

// Module: pixel_framebuffer_scanner
// PURPOSE
//  Consumer end of the plotter pixel-write stream (X, Y, Colour, Plot). Stores each plotted pixel
//  in an on-chip 3-bit frame buffer and continuously scans the buffer out in raster order.
//  Scan-out carries sync/blank timing for the display path. Clears the buffer to black after reset.
//  Sits between the box/clear drawing FSMs and the display output.
// PARAMETERS
//  X_SCREEN_PIXELS  160  active pixels per line; also the address stride
//  Y_SCREEN_PIXELS  120  active lines per frame
//  H_BLANK          8    blank cycles per line; requires H_SYNC+2 <= H_BLANK
//  V_BLANK          4    blank lines per frame; requires V_SYNC+1 <= V_BLANK
//  H_SYNC           4    HSync pulse width in cycles
//  V_SYNC           2    VSync pulse width in lines
// PORTS
//  Clock        in   1   system clock; all state changes on posedge
//  Resetn       in   1   synchronous, active-low reset
//  iX           in   8   write pixel x
//  iY           in   7   write pixel y
//  iColour      in   3   write pixel colour
//  iPlot        in   1   write strobe; one pixel per cycle while high
//  oReady       out  1   1 = clear finished, writes accepted
//  oDropCount   out  8   saturating count of rejected writes
//  oColour      out  3   scanned pixel colour; 0 while blanking
//  oScanX       out  8   x of the pixel on oColour
//  oScanY       out  7   y of the pixel on oColour
//  oActive      out  1   1 = oColour is a visible pixel
//  oHSync       out  1   active-high horizontal sync
//  oVSync       out  1   active-high vertical sync
//  oFrameStart  out  1   one-cycle pulse coincident with pixel (0,0) on the outputs
// BEHAVIOUR
//  Reset: every output is 0 and the FSM enters S_CLEAR. Reset applies mid-clear or mid-frame on
//   the next edge; scan counters restart.
//  FSM S_CLEAR: a 15-bit address counter writes 0 to addr 0..X*Y-1, one address per cycle.
//   After writing X*Y-1 it moves to S_RUN, so oReady rises exactly X*Y cycles after Resetn goes high.
//   In S_CLEAR the scan counters hold at 0 and every output except oDropCount stays 0.
//  FSM S_RUN: stays in S_RUN until reset.
//  Write path: addr = iY*X_SCREEN_PIXELS + iX, computed at 15 bits.
//   Write occurs at the edge where iPlot=1, state=S_RUN, iX<X_SCREEN_PIXELS and iY<Y_SCREEN_PIXELS.
//   Otherwise, with iPlot=1 (including during S_CLEAR), oDropCount increments and saturates at 255.
//  Scan counters: h counts 0..X+H_BLANK-1, v counts 0..Y+V_BLANK-1.
//   h wraps to 0 and increments v; v wraps to 0 after its last line.
//  Read path: the read address comes from (h,v), with 1-cycle latency.
//   All scan outputs are registered and delayed 1 cycle so they stay aligned with the read data.
//   Decoded values: oActive=(h<X && v<Y); oHSync=(h>=X+2 && h<X+2+H_SYNC);
//   oVSync=(v>=Y+1 && v<Y+1+V_SYNC); oFrameStart=(h==0 && v==0).
//   oScanX/oScanY are h/v, zero-extended or truncated to 8/7 bits.
//  Write/read collision: a write and a read to the same address in the same cycle returns the new colour.
//  Throughput: one write and one scan pixel every cycle, with no stalls.
// TESTING
//  Release Resetn -> oReady=0 for exactly 19200 cycles, then 1; first frame oColour=0 at all 19200 active pixels
//  iPlot pulse X=5,Y=3,Colour=3'b101 -> next frame oColour=5 only at oScanX=5,oScanY=3 with oActive=1
//  iPlot at (160,0) then (0,120) -> frame unchanged, oDropCount=2; 300 bad writes -> oDropCount=255
//  Free-run defaults -> line 168 cycles, frame 20832 cycles, oHSync high 4 cycles at oScanX 162..165,
//   oVSync high lines 121..122, one oFrameStart per frame
//  Write colour 3 to the address being read in that cycle -> oColour=3 on the next cycle
//  Resetn low mid-frame after plotting (5,3) -> outputs 0 next cycle; after re-clear (5,3) reads 0

Source files
------------

// File: rtl/pixel_framebuffer_scanner_if.sv
// Pixel-write stream from the drawing FSMs plus the raster scan-out bundle.
// The master modport drives the write side; the slave modport is the frame buffer.
interface pixel_framebuffer_scanner_if;
  logic [7:0] iX;
  logic [6:0] iY;
  logic [2:0] iColour;
  logic       iPlot;
  logic       oReady;
  logic [7:0] oDropCount;
  logic [2:0] oColour;
  logic [7:0] oScanX;
  logic [6:0] oScanY;
  logic       oActive;
  logic       oHSync;
  logic       oVSync;
  logic       oFrameStart;

  modport master (
    output iX, iY, iColour, iPlot,
    input  oReady, oDropCount, oColour, oScanX, oScanY,
    input  oActive, oHSync, oVSync, oFrameStart
  );

  modport slave (
    input  iX, iY, iColour, iPlot,
    output oReady, oDropCount, oColour, oScanX, oScanY,
    output oActive, oHSync, oVSync, oFrameStart
  );
endinterface

// File: rtl/pixel_framebuffer_scanner.sv
// 3-bit frame buffer: accepts plotted pixels, clears to black after reset and
// continuously scans the buffer out in raster order with sync/blank timing.
module pixel_framebuffer_scanner #(
  parameter int unsigned X_SCREEN_PIXELS = 160,
  parameter int unsigned Y_SCREEN_PIXELS = 120,
  parameter int unsigned H_BLANK         = 8,
  parameter int unsigned V_BLANK         = 4,
  parameter int unsigned H_SYNC          = 4,
  parameter int unsigned V_SYNC          = 2
) (
  input logic                          Clock,
  input logic                          Resetn,
  pixel_framebuffer_scanner_if.slave   bus
);

  localparam int unsigned H_TOTAL  = X_SCREEN_PIXELS + H_BLANK;
  localparam int unsigned V_TOTAL  = Y_SCREEN_PIXELS + V_BLANK;
  localparam int unsigned FB_DEPTH = X_SCREEN_PIXELS * Y_SCREEN_PIXELS;
  localparam int unsigned HW       = $clog2(H_TOTAL);
  localparam int unsigned VW       = $clog2(V_TOTAL);
  localparam int unsigned AW       = 15;

  localparam logic [HW-1:0] H_ACT  = HW'(X_SCREEN_PIXELS);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(X_SCREEN_PIXELS + 2);
  localparam logic [HW-1:0] HS_END = HW'(X_SCREEN_PIXELS + 2 + H_SYNC);
  localparam logic [VW-1:0] V_ACT  = VW'(Y_SCREEN_PIXELS);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(Y_SCREEN_PIXELS + 1);
  localparam logic [VW-1:0] VS_END = VW'(Y_SCREEN_PIXELS + 1 + V_SYNC);
  localparam logic [AW-1:0] STRIDE   = AW'(X_SCREEN_PIXELS);
  localparam logic [AW-1:0] CLR_LAST = AW'(FB_DEPTH - 1);
  localparam logic [7:0]    X_LIM    = 8'(X_SCREEN_PIXELS);
  localparam logic [6:0]    Y_LIM    = 7'(Y_SCREEN_PIXELS);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_addr_q;
  logic [HW-1:0]   h_q;
  logic [VW-1:0]   v_q;
  logic [2:0]      mem [FB_DEPTH];

  logic            we_c, drop_c, in_range_c, active_c;
  logic [AW-1:0]   waddr_c, plot_addr_c, rd_addr_c;
  logic [2:0]      wdata_c, rd_data_c;

  assign in_range_c  = (bus.iX < X_LIM) && (bus.iY < Y_LIM);
  assign plot_addr_c = AW'(bus.iY) * STRIDE + AW'(bus.iX);
  assign active_c    = (h_q < H_ACT) && (v_q < V_ACT);
  assign rd_addr_c   = active_c ? (AW'(v_q) * STRIDE + AW'(h_q)) : '0;
  // Write-first bypass so a same-cycle write to the scanned address shows the new colour
  assign rd_data_c   = (we_c && (waddr_c == rd_addr_c)) ? wdata_c : mem[rd_addr_c];

  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= S_CLEAR;
    else         state_q <= state_d;
  end

  // Next state plus selection of the single buffer write port
  always_comb begin
    state_d = state_q;
    we_c    = 1'b0;
    drop_c  = 1'b0;
    waddr_c = clr_addr_q;
    wdata_c = 3'd0;
    case (state_q)
      S_CLEAR: begin
        we_c   = 1'b1;
        drop_c = bus.iPlot;
        if (clr_addr_q == CLR_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.iPlot) begin
          if (in_range_c) begin
            we_c    = 1'b1;
            waddr_c = plot_addr_c;
            wdata_c = bus.iColour;
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn)                 clr_addr_q <= '0;
    else if (state_q == S_CLEAR) clr_addr_q <= clr_addr_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (Resetn && we_c) mem[waddr_c] <= wdata_c;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      bus.oReady     <= 1'b0;
      bus.oDropCount <= 8'd0;
    end else begin
      bus.oReady <= (state_d == S_RUN);
      if (drop_c && (bus.oDropCount != 8'hFF)) bus.oDropCount <= bus.oDropCount + 8'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn || (state_q != S_RUN)) begin
      h_q <= '0;
      v_q <= '0;
    end else if (h_q == H_LAST) begin
      h_q <= '0;
      v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end else begin
      h_q <= h_q + 1'b1;
    end
  end

  // Scan outputs are delayed one cycle to line up with the read data
  always_ff @(posedge Clock) begin
    if (!Resetn || (state_q != S_RUN)) begin
      bus.oColour     <= 3'd0;
      bus.oScanX      <= 8'd0;
      bus.oScanY      <= 7'd0;
      bus.oActive     <= 1'b0;
      bus.oHSync      <= 1'b0;
      bus.oVSync      <= 1'b0;
      bus.oFrameStart <= 1'b0;
    end else begin
      bus.oColour     <= active_c ? rd_data_c : 3'd0;
      bus.oScanX      <= 8'(h_q);
      bus.oScanY      <= 7'(v_q);
      bus.oActive     <= active_c;
      bus.oHSync      <= (h_q >= HS_BEG) && (h_q < HS_END);
      bus.oVSync      <= (v_q >= VS_BEG) && (v_q < VS_END);
      bus.oFrameStart <= (h_q == '0) && (v_q == '0);
    end
  end

endmodule
